axis_sniffer_capture_ctrl: RTL
==============================

# axis_sniffer_capture_ctrl

Capture sequencer for the AXI-Stream sniffer tap. It watches the sniffed stream (data plus handshake qualifier), decimates it and writes a software-sized block of samples into a simple dual-port BRAM write port. It reports busy/done status to the register bank. An optional level trigger can gate the start of capture. It never back-pressures the monitored stream.

## Interface
- `DATA_WIDTH`, 32, width of sniffed data and BRAM write data
- `ADDR_WIDTH`, 10, BRAM word address width; maximum capture length 2^ADDR_WIDTH
- `DECIM_WIDTH`, 16, width of the decimation ratio
---
- `aclk`  in  1  single clock for all logic
- `aresetn`  in  1  asynchronous, active-low reset
- `t_data`  in  DATA_WIDTH  sniffed tdata
- `t_beat`  in  1  sniffed transfer qualifier (tvalid & tready); high means t_data is a real sample this cycle
- `cfg_start`  in  1  one-cycle start pulse
- `cfg_abort`  in  1  one-cycle abort pulse
- `cfg_length`  in  ADDR_WIDTH  number of samples minus one
- `cfg_decim`  in  DECIM_WIDTH  keep 1 of every cfg_decim+1 beats
- `cfg_threshold`  in  DATA_WIDTH  signed trigger level (used only with trigger compiled in)
- `bram_addr`  out  ADDR_WIDTH  write address
- `bram_wdata`  out  DATA_WIDTH  write data
- `bram_we`  out  1  write enable
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  level; high after a complete capture until the next start

## Operation
- The block has four states: IDLE, ARMED, CAPTURE and DONE.
- **Start:** `cfg_start` is honoured only in IDLE or DONE. While `busy` it is ignored.
  - On start, the block latches `cfg_length`, `cfg_decim` and `cfg_threshold`, clears `done` and the address and decimation counters.
  - It then moves to ARMED (trigger compiled in) or CAPTURE (trigger compiled out).
- **ARMED:** transition to CAPTURE happens on the first `t_beat` whose signed `t_data` is >= threshold while the previous beat's data was < threshold.
  - The previous-beat register is cleared to the most negative value at start, so the first beat may trigger.
  - The triggering beat is captured as sample 0.
- **CAPTURE:** decimation counter `dcnt` (DECIM_WIDTH).
  - On each `t_beat`: if `dcnt`==0, accept the sample and reload `dcnt` with the latched decim; otherwise decrement `dcnt`.
  - `cfg_decim`=0 accepts every beat.
  - Non-beat cycles change nothing.
- **Accepted sample:** drive `bram_we`=1, `bram_wdata`=sample and `bram_addr`=sample index on the next cycle (registered).
  - When the index equals the latched length, go to DONE.
  - `done` rises in the same cycle as the last `bram_we`.
  - Address never wraps; exactly length+1 writes occur.
- **DONE:** holds `done`=1 and accepts a new `cfg_start`.
- **Abort:** `cfg_abort` in any state goes to IDLE next cycle.
  - `done` is cleared and no further `bram_we` is issued; a write already registered in the abort cycle still completes.
  - Abort and start in the same cycle: abort wins.
- **Config changes:** changes to `cfg_*` while busy have no effect.

## Timing
- **Reset:** all outputs 0 and state IDLE. Reset mid-capture drops everything immediately; the BRAM contents are undefined/partial.
- **Start to capture:** start pulse at cycle N puts the block in CAPTURE/ARMED at N+1. A beat at N+1 can be accepted, and its write appears at N+2.
- **Throughput:** one write per cycle maximum (decim 0, continuous beats).
- **Write latency:** an accepted beat produces its write exactly 1 cycle later.
- **Status:** `busy` is registered from state. `done` and `busy` are never high together.

## Configuration
- `AXIS_SNIFFER_CAPTURE_TRIGGER_EN`
  - **Defined:** ARMED state and threshold compare are present; capture starts on the rising crossing.
  - **Undefined:** ARMED is removed, `cfg_threshold` is unused, and start goes straight to CAPTURE.

## Test plan
- **Basic capture:** length=3, decim=0, continuous beats with data 10,11,12,13,14 after start → writes addr0..3 = 10..13 on consecutive cycles; `done`=1 with the last write; `busy`=0 after.
- **Decimation with gaps:** decim=2, length=1, beats with data 0..9 with t_beat gaps → writes data 0 at addr0 and 3 at addr1 only; gap cycles do not advance the counter.
- **Trigger (macro defined):** threshold=100 signed, data −5,50,99,100,120,… → capture starts at 100 (addr0=100).
- **Trigger polarity/non-crossing (macro defined):** data held at 200 from start → the first beat triggers once; a stream of 50s never leaves ARMED.
- **Abort:** abort mid-capture after 2 writes → no further `bram_we`; `done`=0, `busy`=0. Simultaneous start+abort in DONE → IDLE with `done`=0.
- **Start while busy and reset mid-capture:** start pulsed while busy is ignored and the address sequence is uninterrupted. `aresetn` low mid-capture → all outputs 0 asynchronously. A fresh start after release captures from addr0.

Source files
------------

// File: rtl/axis_sniffer_capture_ctrl.sv
// Capture sequencer for the AXI-Stream sniffer tap: decimates the sniffed stream into a BRAM write port.
// Define AXIS_SNIFFER_CAPTURE_TRIGGER_EN to add the ARMED state and the signed rising-crossing level trigger.
module axis_sniffer_capture_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DECIM_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_WIDTH-1:0]  t_data,
  input  logic                   t_beat,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [ADDR_WIDTH-1:0]  cfg_length,
  input  logic [DECIM_WIDTH-1:0] cfg_decim,
  input  logic [DATA_WIDTH-1:0]  cfg_threshold,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_wdata,
  output logic                   bram_we,
  output logic                   busy,
  output logic                   done
);

`ifdef AXIS_SNIFFER_CAPTURE_TRIGGER_EN
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
`endif

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dcnt;
  logic                   accept;

`ifdef AXIS_SNIFFER_CAPTURE_TRIGGER_EN
  logic signed [DATA_WIDTH-1:0] thr_q;
  logic signed [DATA_WIDTH-1:0] prev_q;
  logic                         trig;

  // The triggering beat itself becomes sample 0, so it counts as accepted.
  assign trig   = t_beat && ($signed(t_data) >= thr_q) && (prev_q < thr_q);
  assign accept = (state == CAPTURE && t_beat && dcnt == '0) || (state == ARMED && trig);
`else
  logic unused_thr;
  assign unused_thr = ^cfg_threshold;
  assign accept     = (state == CAPTURE) && t_beat && (dcnt == '0);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      decim_q    <= '0;
      dcnt       <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef AXIS_SNIFFER_CAPTURE_TRIGGER_EN
      thr_q      <= '0;
      prev_q     <= '0;
`endif
    end else begin
      bram_we <= 1'b0;
      if (cfg_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (cfg_start) begin
              len_q   <= cfg_length;
              decim_q <= cfg_decim;
              idx     <= '0;
              dcnt    <= '0;
              done    <= 1'b0;
              busy    <= 1'b1;
`ifdef AXIS_SNIFFER_CAPTURE_TRIGGER_EN
              thr_q   <= cfg_threshold;
              prev_q  <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
              state   <= ARMED;
`else
              state   <= CAPTURE;
`endif
            end
          end
`ifdef AXIS_SNIFFER_CAPTURE_TRIGGER_EN
          ARMED: begin
            if (t_beat) prev_q <= t_data;
            if (trig)   state  <= CAPTURE;
          end
`endif
          CAPTURE: begin
            if (t_beat && dcnt != '0) dcnt <= dcnt - 1'b1;
          end
          default: ;
        endcase

        // Accepted samples override the state update above when they finish the block.
        if (accept) begin
          bram_we    <= 1'b1;
          bram_wdata <= t_data;
          bram_addr  <= idx;
          dcnt       <= decim_q;
          if (idx == len_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule
